// File: rtl/clkgate_ctrl_pkg.sv
// clkgate_ctrl_pkg: shared state encoding and constants for the clock-gate enable controller.
package clkgate_ctrl_pkg;
    typedef enum logic [1:0] {ST_RUN, ST_COUNT, ST_GATED, ST_WAKE} state_t;
    localparam int SETTLE_MIN = 1;
    localparam int SETTLE_MAX = 15;
    localparam int STATS_W    = 32;
endpackage

// File: rtl/clkgate_sat_counter.sv
// clkgate_sat_counter: saturating up-counter with synchronous clear (clear wins over increment).
module clkgate_sat_counter #(
    parameter int W = 8
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_clr,
    input  logic         i_inc,
    output logic [W-1:0] o_q
);
    logic [W-1:0] r_q;
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)                 r_q <= '0;
        else if (i_clr)               r_q <= '0;
        else if (i_inc && r_q != '1)  r_q <= r_q + 1'b1;
    end
    assign o_q = r_q;
endmodule

// File: rtl/clkgate_enable_ctrl.sv
// clkgate_enable_ctrl: idle-detect FSM driving the E pin of a latch-based ICG, with 4-phase wake handshake.
// Define CLKGATE_STATS_EN to add STATS_CLR / GATED_CNT (count of CLK edges seen with E=0).
module clkgate_enable_ctrl
    import clkgate_ctrl_pkg::*;
#(
    parameter int CNT_W  = 8,
    parameter int SETTLE = 2
) (
    input  logic             CLK,
    input  logic             RN,
    input  logic             BUSY,
    input  logic             WAKE_REQ,
    output logic             WAKE_ACK,
    input  logic             FORCE_ON,
    input  logic [CNT_W-1:0] IDLE_CYC,
    output logic             E,
    output logic             GATED
`ifdef CLKGATE_STATS_EN
    ,
    input  logic             STATS_CLR,
    output logic [STATS_W-1:0] GATED_CNT
`endif
);
    localparam int SW = $clog2(SETTLE_MAX + 1);

    state_t           r_state, w_next;
    logic             r_e, r_ack, w_ack_next, w_wake;
    logic [SW-1:0]    r_settle;
    logic [CNT_W-1:0] w_idle;
    logic [CNT_W:0]   w_cnt_p1;

    // ACK feeds back into wake so the clock can never be gated mid-handshake
    assign w_wake     = BUSY | WAKE_REQ | FORCE_ON | r_ack;
    assign w_cnt_p1   = {1'b0, w_idle} + 1'b1;
    assign w_ack_next = WAKE_REQ && (r_state == ST_RUN || r_state == ST_COUNT);

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_RUN:   if (IDLE_CYC != '0 && !w_wake)
                          w_next = (IDLE_CYC == CNT_W'(1)) ? ST_GATED : ST_COUNT;
            ST_COUNT: if (w_wake || IDLE_CYC == '0) w_next = ST_RUN;
                      else if (w_cnt_p1 >= {1'b0, IDLE_CYC}) w_next = ST_GATED;
            ST_GATED: if (w_wake) w_next = ST_WAKE;
            ST_WAKE:  if (r_settle == SW'(SETTLE - 1)) w_next = ST_RUN;
            default:  w_next = ST_RUN;
        endcase
    end

    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            r_state  <= ST_RUN;
            r_e      <= 1'b1;
            r_ack    <= 1'b0;
            r_settle <= '0;
        end else begin
            r_state  <= w_next;
            r_e      <= (w_next != ST_GATED);
            r_ack    <= w_ack_next;
            r_settle <= (r_state == ST_WAKE) ? r_settle + 1'b1 : '0;
        end
    end

    clkgate_sat_counter #(.W(CNT_W)) u_idle_cnt (
        .i_clk   (CLK),
        .i_rst_n (RN),
        .i_clr   (w_next != ST_COUNT),
        .i_inc   (w_next == ST_COUNT),
        .o_q     (w_idle)
    );

`ifdef CLKGATE_STATS_EN
    clkgate_sat_counter #(.W(STATS_W)) u_gated_cnt (
        .i_clk   (CLK),
        .i_rst_n (RN),
        .i_clr   (STATS_CLR),
        .i_inc   (!r_e),
        .o_q     (GATED_CNT)
    );
`endif

    assign E        = r_e;
    assign GATED    = ~r_e;
    assign WAKE_ACK = r_ack;
endmodule

// File: tb/tb_clkgate_enable_ctrl.sv
// tb_clkgate_enable_ctrl: directed-vector bench for clkgate_enable_ctrl (CNT_W=8, SETTLE=2).
module tb_clkgate_enable_ctrl;
    logic       CLK = 1'b0;
    logic       RN = 1'b0;
    logic       BUSY = 1'b1;
    logic       WAKE_REQ = 1'b0;
    logic       FORCE_ON = 1'b0;
    logic [7:0] IDLE_CYC = 8'd4;
    logic       WAKE_ACK, E, GATED;
`ifdef CLKGATE_STATS_EN
    logic        STATS_CLR = 1'b0;
    logic [31:0] GATED_CNT;
`endif
    int n_chk = 0;
    int n_bad = 0;

    always #5 CLK = ~CLK;

    clkgate_enable_ctrl #(.CNT_W(8), .SETTLE(2)) dut (
        .CLK      (CLK),
        .RN       (RN),
        .BUSY     (BUSY),
        .WAKE_REQ (WAKE_REQ),
        .WAKE_ACK (WAKE_ACK),
        .FORCE_ON (FORCE_ON),
        .IDLE_CYC (IDLE_CYC),
        .E        (E),
        .GATED    (GATED)
`ifdef CLKGATE_STATS_EN
        ,
        .STATS_CLR(STATS_CLR),
        .GATED_CNT(GATED_CNT)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge CLK);
    endtask

    initial begin
        logic e_all;
        tick(2);
        chk("rst_e", E, 1);
        chk("rst_gated", GATED, 0);
        chk("rst_ack", WAKE_ACK, 0);
        RN = 1'b1;
        e_all = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            e_all &= E & ~GATED & ~WAKE_ACK;
        end
        chk("busy_hold", e_all, 1);

        BUSY = 1'b0;
        tick(3);
        chk("idle3_e", E, 1);
        tick(1);
        chk("idle4_e", E, 0);
        chk("idle4_gated", GATED, 1);

        WAKE_REQ = 1'b1;
        tick(1);
        chk("wake_e", E, 1);
        chk("wake_gated", GATED, 0);
        chk("wake_ack1", WAKE_ACK, 0);
        tick(2);
        chk("wake_ack3", WAKE_ACK, 0);
        tick(1);
        chk("wake_ack4", WAKE_ACK, 1);
        tick(5);
        chk("ack_hold", WAKE_ACK, 1);
        chk("ack_hold_e", E, 1);
        WAKE_REQ = 1'b0;
        tick(1);
        chk("ack_fall", WAKE_ACK, 0);
        chk("ack_fall_e", E, 1);
        tick(3);
        chk("regate_pre", E, 1);
        tick(1);
        chk("regate", E, 0);

        BUSY = 1'b1;
        tick(4);
        chk("busy_wake", E, 1);
        BUSY = 1'b0;
        tick(2);
        BUSY = 1'b1;
        tick(1);
        BUSY = 1'b0;
        tick(1);
        chk("restart1", E, 1);
        tick(2);
        chk("restart3", E, 1);
        tick(1);
        chk("restart4", E, 0);

        WAKE_REQ = 1'b1;
        tick(1);
        WAKE_REQ = 1'b0;
        tick(1);
        chk("drop_e", E, 1);
        chk("drop_ack", WAKE_ACK, 0);
        tick(2);
        chk("drop_ack_run", WAKE_ACK, 0);
        tick(2);
        chk("drop_regate_pre", E, 1);
        tick(1);
        chk("drop_regate", E, 0);

        FORCE_ON = 1'b1;
        e_all = 1'b1;
        for (int i = 0; i < 300; i++) begin
            tick(1);
            e_all &= E;
        end
        chk("force_hold", e_all, 1);
        FORCE_ON = 1'b0;
        IDLE_CYC = 8'd0;
        e_all = 1'b1;
        for (int i = 0; i < 300; i++) begin
            tick(1);
            e_all &= E;
        end
        chk("idle0_hold", e_all, 1);

        IDLE_CYC = 8'd1;
        tick(1);
        chk("idle1_e", E, 0);
        chk("idle1_gated", GATED, 1);
`ifdef CLKGATE_STATS_EN
        STATS_CLR = 1'b1;
        tick(1);
        chk("stats_clr0", GATED_CNT, 0);
        STATS_CLR = 1'b0;
        tick(10);
        chk("stats_10", GATED_CNT, 10);
        STATS_CLR = 1'b1;
        tick(1);
        chk("stats_clr1", GATED_CNT, 0);
        STATS_CLR = 1'b0;
`endif

        BUSY = 1'b1;
        tick(4);
        IDLE_CYC = 8'd8;
        BUSY = 1'b0;
        tick(3);
        chk("lower_pre", E, 1);
        IDLE_CYC = 8'd2;
        tick(1);
        chk("lower_gate", E, 0);

        BUSY = 1'b1;
        tick(4);
        IDLE_CYC = 8'd4;
        BUSY = 1'b0;
        tick(3);
        BUSY = 1'b1;
        tick(1);
        chk("wake_wins", E, 1);

        BUSY = 1'b0;
        IDLE_CYC = 8'd1;
        tick(1);
        chk("pre_rst_e", E, 0);
        #1 RN = 1'b0;
        #1;
        chk("async_rst_e", E, 1);
        chk("async_rst_gated", GATED, 0);
        BUSY = 1'b1;
        IDLE_CYC = 8'd4;
        #1 RN = 1'b1;
        tick(1);
        chk("post_rst_e", E, 1);
        BUSY = 1'b0;
        tick(3);
        chk("post_rst_cnt3", E, 1);
        tick(1);
        chk("post_rst_cnt4", E, 0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
